// File: rtl/ram_word_array_pkg.sv
// Shared definitions for the word-array data memory: word width and FSM state encoding.
package ram_word_array_pkg;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/ram_word.sv
// One 16-bit storage cell: a plain register behind a load/hold mux, never reset
// so that only the clear sweep in the parent initialises it.
module ram_word
  import ram_word_array_pkg::*;
(
  input  logic              clk,
  input  logic              load,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);
  logic [WORD_W-1:0] q_reg;
  logic [WORD_W-1:0] q_next;

  always_comb q_next = load ? d : q_reg;

  always_ff @(posedge clk) q_reg <= q_next;

  assign q = q_reg;
endmodule

// File: rtl/ram_word_array.sv
// Word-addressable data memory with request/response handshakes and a
// post-reset clear sweep; all outputs come straight from flops.
module ram_word_array
  import ram_word_array_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] init_cnt_reg, init_cnt_next;
  logic              req_ready_reg, req_ready_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              init_busy_reg, init_busy_next;
  logic [WORD_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_err_reg, rsp_err_next;

  logic              accept;
  logic              addr_ok;
  logic [WORD_W-1:0] wr_data;
  logic [WORD_W-1:0] rd_word;
  logic [DEPTH-1:0]  load;
  logic [WORD_W-1:0] word_q [DEPTH];

  assign accept  = (state_reg == ST_IDLE) && req_valid;
  assign addr_ok = {1'b0, req_addr} < DEPTH_EXT;
  assign wr_data = (state_reg == ST_INIT) ? '0 : req_wdata;

  // Each cell loads either from the clear sweep or from an accepted in-range write.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      assign load[gi] = ((state_reg == ST_INIT) && (init_cnt_reg == ADDR_W'(gi))) ||
                        (accept && req_we && (req_addr == ADDR_W'(gi)));
      ram_word u_word (
        .clk  (clk),
        .load (load[gi]),
        .d    (wr_data),
        .q    (word_q[gi])
      );
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req_addr == ADDR_W'(i)) rd_word = word_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_INIT;
      init_cnt_reg  <= '0;
      req_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      init_busy_reg <= 1'b1;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_cnt_reg  <= init_cnt_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      init_busy_reg <= init_busy_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    case (state_reg)
      ST_INIT: begin
        if (init_cnt_reg == LAST_ADDR) state_next = ST_IDLE;
        else init_cnt_next = init_cnt_reg + 1'b1;
      end
      ST_IDLE: if (req_valid) state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_INIT;
    endcase
  end

  // Handshake flags are decoded from the next state so they appear as flop outputs.
  always_comb begin
    req_ready_next = (state_next == ST_IDLE);
    rsp_valid_next = (state_next == ST_RESP);
    init_busy_next = (state_next == ST_INIT);
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    if (accept) begin
      rsp_err_next = !addr_ok;
      if (!addr_ok)    rsp_rdata_next = '0;
      else if (req_we) rsp_rdata_next = req_wdata;
      else             rsp_rdata_next = rd_word;
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign init_busy = init_busy_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
endmodule

// File: doc/ram_word_array.md
# ram_word_array

Word-addressable 16-bit data memory built from an array of 16-bit storage words, sitting directly downstream of the CPU/bus master and wrapping the existing 16-bit register as its storage cell. It accepts one read or write request at a time over a valid/ready handshake and returns a response over a second valid/ready handshake. After every reset it sweeps all words to zero before accepting traffic.

## Interface
Parameters:
- DEPTH, 8: number of 16-bit words, 2..256.
- ADDR_W, 8: request address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  16  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  master accepts response.
- rsp_rdata  out  16  read data, or echoed write data for writes.
- rsp_err  out  1  request address >= DEPTH.
- init_busy  out  1  clear sweep in progress.

## Operation
- States: INIT, IDLE, RESP.
- INIT: init counter walks 0..DEPTH-1, writing 16'h0000 to one word per cycle; init_busy = 1, req_ready = 0. After writing word DEPTH-1 -> IDLE.
- IDLE: req_ready = 1. On req_valid & req_ready: latch response, -> RESP.
  - Write, addr < DEPTH: word[addr] <= req_wdata at that edge; rsp_rdata = req_wdata, rsp_err = 0.
  - Read, addr < DEPTH: rsp_rdata = word[addr] sampled at that edge; rsp_err = 0.
  - Addr >= DEPTH: no storage change; rsp_rdata = 16'h0000, rsp_err = 1.
- RESP: rsp_valid = 1, req_ready = 0; rsp_rdata/rsp_err held stable until rsp_valid & rsp_ready, then -> IDLE.
- Request fields are ignored unless handshake completes; req_* may change freely while req_ready = 0.
- Storage words are not reset directly; only the INIT sweep clears them.

## Timing
- Reset asserted (any state, any cycle): immediately state = INIT, init counter = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_busy = 1. Pending response is discarded. Cycle in flight write is lost.
- First rising edge after reset release clears word 0; word DEPTH-1 cleared on edge DEPTH; req_ready and init_busy = 0 visible in the cycle after that edge (DEPTH cycles of busy).
- Request accepted at edge N -> rsp_valid = 1 from edge N through the edge where rsp_ready = 1.
- rsp_ready high in first RESP cycle -> IDLE next cycle; peak throughput one transaction per 2 cycles.
- Read-after-write to same address in consecutive transactions returns the new data (write completes at acceptance edge).
- rsp_ready while rsp_valid = 0 has no effect.
- All outputs registered; no combinational path from any input to any output.

## Structure
- Shared package: state encoding constants (INIT, IDLE, RESP), WORD_W = 16.
- Sub-module: ram_word — one 16-bit storage cell with load enable, wrapping the existing 16-bit register with a hold mux; instantiated DEPTH times via generate.
- Top level holds FSM, init counter, address decode, read mux and response registers.

## Test plan
- Reset release, DEPTH = 8: init_busy high exactly 8 cycles, req_ready low throughout; then read each of addrs 0..7 -> rsp_rdata = 16'h0000, rsp_err = 0.
- Write 16'hBEEF to addr 3, then read addr 3 -> write rsp echoes 16'hBEEF; read rsp 16'hBEEF; read addr 2 -> 16'h0000.
- Write 16'h1234 to addr 9 (DEPTH = 8) -> rsp_err = 1, rsp_rdata = 0; subsequent reads of 0..7 unchanged.
- Read addr 3 with rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable for all 5, req_ready low, second req_valid ignored; rsp_ready high -> req_ready returns next cycle.
- Write 16'hA5A5 to addr 5, assert reset_n low mid-RESP -> rsp_valid drops immediately; after INIT, read addr 5 -> 16'h0000.
- Back-to-back write 16'h0001/addr 0 then read addr 0 with rsp_ready tied high -> transactions accepted every 2 cycles, read returns 16'h0001.
